uart_tx: RTL and testbench

Transmit half of the UART pair. It accepts a parallel word through a valid/ready handshake and serialises it onto the line as start bit, data bits (LSB first), optional parity bit and one or more stop bits. Its output drives the same serial line that uart_rx samples, and its parameters mirror uart_rx so one parameter set configures both ends of a link.

---
 rtl/uart_tx.sv | 181 ++++++++++++++++++
 tb/tb_uart_tx.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: transmit half of a UART link.
// Accepts a word through a valid/ready handshake and sends it as:
// start bit, data bits LSB first, an optional even-parity bit, then stop bits.
// Every bit lasts exactly BAUD_DIV clocks. All outputs come straight from flops.
module uart_tx #(
    parameter int BAUD_DIV      = 434,  // clk cycles per serial bit, 2..65535
    parameter int DATA_BITS     = 8,    // data bits per frame, 5..9
    parameter int ENABLE_PARITY = 1,    // 1 inserts an even-parity bit
    parameter int STOP_BIT      = 1     // number of stop bits, 1..2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    // Terminal counts, sized to match the counters they are compared with.
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [3:0]  BIT_LAST  = 4'(DATA_BITS - 1);
    localparam logic        STOP_LAST = 1'(STOP_BIT - 1);

    state_e               state_q,    state_d;
    logic [15:0]          baud_cnt_q, baud_cnt_d;
    logic [3:0]           bit_cnt_q,  bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic [DATA_BITS-1:0] shift_q,    shift_d;
    logic                 parity_q,   parity_d;
    logic                 tx_q,       tx_d;
    logic                 tx_ready_q, tx_ready_d;
    logic                 busy_q,     busy_d;
    logic                 tx_done_q,  tx_done_d;
    logic                 baud_last;

    assign baud_last = (baud_cnt_q == BAUD_LAST);

    // Next-state and next-output logic; outputs are decided one cycle ahead
    // so the line changes on the same edge as the state.
    always_comb begin
        // NOTE: every _d gets a default (hold, or 0 for the done pulse) before
        // the case, so no path leaves a variable unassigned and no latch forms.
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        tx_d       = tx_q;
        tx_ready_d = tx_ready_q;
        busy_d     = busy_q;
        tx_done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d       = 1'b1;
                tx_ready_d = 1'b1;
                busy_d     = 1'b0;
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
                stop_cnt_d = 1'b0;
                if (tx_valid) begin
                    shift_d    = tx_data;
                    parity_d   = ^tx_data;
                    state_d    = START;
                    tx_d       = 1'b0;
                    tx_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end

            START: begin
                baud_cnt_d = baud_last ? 16'd0 : baud_cnt_q + 16'd1;
                if (baud_last) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end

            DATA: begin
                baud_cnt_d = baud_last ? 16'd0 : baud_cnt_q + 16'd1;
                if (baud_last) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        if (ENABLE_PARITY != 0) begin
                            state_d = PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        tx_d      = shift_q[1];
                    end
                end
            end

            PARITY: begin
                baud_cnt_d = baud_last ? 16'd0 : baud_cnt_q + 16'd1;
                if (baud_last) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end

            STOP: begin
                baud_cnt_d = baud_last ? 16'd0 : baud_cnt_q + 16'd1;
                tx_d       = 1'b1;
                if (baud_last) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        stop_cnt_d = 1'b0;
                        state_d    = IDLE;
                        tx_ready_d = 1'b1;
                        busy_d     = 1'b0;
                        tx_done_d  = 1'b1;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                // Unused encodings fall back to a quiet idle line.
                state_d    = IDLE;
                tx_d       = 1'b1;
                tx_ready_d = 1'b1;
                busy_d     = 1'b0;
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
                stop_cnt_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset to an idle line.
    always_ff @(posedge clk) begin
        // NOTE: flops use non-blocking assignments so every register samples
        // the pre-edge values; the comb block above uses blocking ones.
        if (rst) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign tx       = tx_q;
    assign tx_ready = tx_ready_q;
    assign busy     = busy_q;
    assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: several uart_tx instances with different parameter sets share
// one stimulus stream. A frame-level model predicts every output on every
// cycle, a behavioural receiver decodes one instance's line, and directed
// phases pin the model with hand-written frames.
module tb_uart_tx;

    localparam int NDUT = 5;
    localparam int BAUD_T [NDUT] = '{4, 4, 16, 2, 3};
    localparam int DB_T   [NDUT] = '{8, 8, 8,  5, 9};
    localparam int PAR_T  [NDUT] = '{1, 0, 1,  1, 0};
    localparam int STP_T  [NDUT] = '{1, 2, 1,  2, 1};
    localparam int LB = 2;  // instance decoded by the receiver

    logic       clk;
    logic       rst;
    logic       tx_valid;
    logic [8:0] tx_data;
    logic       tx_w    [NDUT];
    logic       ready_w [NDUT];
    logic       busy_w  [NDUT];
    logic       done_w  [NDUT];

    int n_cmp = 0;
    int n_bad = 0;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int DB = DB_T[g];
        uart_tx #(
            .BAUD_DIV      (BAUD_T[g]),
            .DATA_BITS     (DB),
            .ENABLE_PARITY (PAR_T[g]),
            .STOP_BIT      (STP_T[g])
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .tx_valid (tx_valid),
            .tx_data  (tx_data[DB-1:0]),
            .tx_ready (ready_w[g]),
            .tx       (tx_w[g]),
            .busy     (busy_w[g]),
            .tx_done  (done_w[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole frame as a bit vector, index 0 = start bit, stop bits as trailing 1s.
    function automatic logic [15:0] build_frame(input int i, input logic [8:0] d);
        logic [15:0] f;
        logic        p;
        f    = '1;
        f[0] = 1'b0;
        p    = 1'b0;
        for (int j = 0; j < DB_T[i]; j++) begin
            f[1+j] = d[j];
            p      = p ^ d[j];
        end
        if (PAR_T[i] != 0) f[1+DB_T[i]] = p;
        return f;
    endfunction

    function automatic int frame_len(input int i);
        return 1 + DB_T[i] + PAR_T[i] + STP_T[i];
    endfunction

    // ---------------- behavioural model ----------------
    bit          chk_en = 1'b0;
    bit          m_active [NDUT];
    bit          m_done   [NDUT];
    int          m_cnt    [NDUT];
    logic [15:0] m_bits   [NDUT];
    logic [7:0]  sent_q [$];
    int          rst_epoch = 0;

    initial begin
        for (int i = 0; i < NDUT; i++) begin
            m_active[i] = 1'b0;
            m_done[i]   = 1'b0;
            m_cnt[i]    = 0;
            m_bits[i]   = '1;
        end
    end

    always @(posedge clk) begin
        chk_en = 1'b1;
        for (int i = 0; i < NDUT; i++) begin
            if (rst) begin
                m_active[i] = 1'b0;
                m_done[i]   = 1'b0;
            end else if (m_active[i]) begin
                m_cnt[i]++;
                m_done[i] = 1'b0;
                if (m_cnt[i] == frame_len(i) * BAUD_T[i]) begin
                    m_active[i] = 1'b0;
                    m_done[i]   = 1'b1;
                end
            end else begin
                m_done[i] = 1'b0;
                if (tx_valid) begin
                    m_active[i] = 1'b1;
                    m_cnt[i]    = 0;
                    m_bits[i]   = build_frame(i, tx_data);
                    if (i == LB) sent_q.push_back(tx_data[7:0]);
                end
            end
        end
        if (rst) begin
            sent_q.delete();
            rst_epoch++;
        end
    end

    // Every-cycle comparison of {tx, tx_ready, busy, tx_done} for all instances.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NDUT; i++) begin
                logic [3:0] exp_v;
                logic [3:0] act_v;
                if (m_active[i]) exp_v = {m_bits[i][m_cnt[i] / BAUD_T[i]], 3'b010};
                else             exp_v = {3'b110, m_done[i]};
                act_v = {tx_w[i], ready_w[i], busy_w[i], done_w[i]};
                check($sformatf("cycle_dut%0d", i), 32'(act_v), 32'(exp_v));
            end
        end
    end

    // ---------------- behavioural receiver on instance LB ----------------
    int         seen_epoch = 0;
    bit         rx_busy = 1'b0;
    int         rx_t = 0;
    int         rx_cnt = 0;
    logic [7:0] rx_word = '0;

    always @(negedge clk) begin
        if (seen_epoch != rst_epoch) begin
            seen_epoch = rst_epoch;
            rx_busy    = 1'b0;
        end else if (!rx_busy) begin
            if (tx_w[LB] == 1'b0) begin
                rx_busy = 1'b1;
                rx_t    = 0;
            end
        end else begin
            rx_t++;
            if (rx_t % 16 == 8) begin
                int k;
                k = rx_t / 16;
                if (k == 0) begin
                    check("rx_start", 32'(tx_w[LB]), 32'd0);
                end else if (k <= 8) begin
                    rx_word[k-1] = tx_w[LB];
                end else if (k == 9) begin
                    check("rx_parity", 32'(tx_w[LB]), 32'(^rx_word));
                end else begin
                    check("rx_stop", 32'(tx_w[LB]), 32'd1);
                    if (sent_q.size() == 0) begin
                        check("rx_queue_nonempty", 32'd0, 32'd1);
                    end else begin
                        logic [7:0] e;
                        e = sent_q.pop_front();
                        check("rx_word", 32'(rx_word), 32'(e));
                    end
                    rx_cnt++;
                    rx_busy = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int c = 0; c < 3000 && !idle; c++) begin
            @(negedge clk);
            idle = 1'b1;
            for (int i = 0; i < NDUT; i++)
                if (!ready_w[i] || m_active[i]) idle = 1'b0;
        end
        check("wait_idle", 32'(idle), 32'd1);
    endtask

    // Sends one word to all idle instances and checks instances 0 and 1
    // against hand-written frames (44 clks each, done at sample 44).
    task automatic run_directed(input logic [8:0] d, input logic [10:0] lit0, input logic [10:0] lit1);
        logic [45:0] c0, c1, d0, d1;
        int bad0, bad1, n0, n1, i0, i1;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk);
        tx_valid = 1'b0;
        for (int k = 0; k < 46; k++) begin
            if (k > 0) @(negedge clk);
            c0[k] = tx_w[0];
            c1[k] = tx_w[1];
            d0[k] = done_w[0];
            d1[k] = done_w[1];
        end
        bad0 = 0; bad1 = 0; n0 = 0; n1 = 0; i0 = -1; i1 = -1;
        for (int k = 0; k < 44; k++) begin
            if (c0[k] !== lit0[k/4]) bad0++;
            if (c1[k] !== lit1[k/4]) bad1++;
        end
        for (int k = 0; k < 46; k++) begin
            if (d0[k]) begin n0++; if (i0 < 0) i0 = k; end
            if (d1[k]) begin n1++; if (i1 < 0) i1 = k; end
        end
        check($sformatf("frame0_bits_%0h", d), 32'(bad0), 32'd0);
        check($sformatf("frame1_bits_%0h", d), 32'(bad1), 32'd0);
        check("frame0_done_at", 32'(i0), 32'd44);
        check("frame1_done_at", 32'(i1), 32'd44);
        check("frame0_done_count", 32'(n0), 32'd1);
        check("frame1_done_count", 32'(n1), 32'd1);
        check("frame0_idle_after", 32'(c0[44]), 32'd1);
        wait_idle();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] lf;
        int          d_idx, s_idx, rx_before;

        rst      = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 9'h0A5;

        // Model pins: hand-written frames.
        lf = build_frame(0, 9'h0A5);
        check("model_a5", 32'(lf[10:0]), 32'(11'b1_0_10100101_0));
        lf = build_frame(1, 9'h007);
        check("model_07_nopar", 32'(lf[10:0]), 32'(11'b1_1_00000111_0));
        lf = build_frame(4, 9'h1FF);
        check("model_1ff_9bit", 32'(lf[10:0]), 32'(11'b1_111111111_0));

        // Reset held 3 clks with tx_valid high.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_hold", 32'({tx_w[0], ready_w[0], busy_w[0], done_w[0]}), 32'h0000_000C);
        end
        rst = 1'b0;
        tx_valid = 1'b0;

        // Single frames with hand-computed waveforms.
        run_directed(9'h0A5, 11'b1_0_10100101_0, 11'b1_1_10100101_0);
        run_directed(9'h007, 11'b1_1_00000111_0, 11'b1_1_00000111_0);

        // Back-to-back: 0x55 then 0x3C with tx_valid held; data changes mid-frame.
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 9'h055;
        @(negedge clk);
        tx_data  = 9'h03C;
        d_idx = -1;
        s_idx = -1;
        for (int k = 0; k < 200 && s_idx < 0; k++) begin
            if (k > 0) @(negedge clk);
            if (d_idx < 0 && done_w[0]) d_idx = k;
            else if (d_idx >= 0 && tx_w[0] == 1'b0) s_idx = k;
        end
        tx_valid = 1'b0;
        check("b2b_gap", 32'(s_idx - d_idx), 32'd1);
        check("b2b_first_done", 32'(d_idx), 32'd44);
        wait_idle();

        // Reset during data bit 3 of instance 0.
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 9'h0A5;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (17) @(negedge clk);
        check("pre_rst_busy", 32'(busy_w[0]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid", 32'({tx_w[0], ready_w[0], busy_w[0], done_w[0]}), 32'h0000_000C);
        rst = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 9'h03C;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_idle();

        // Loopback words through the receiver.
        rx_before = rx_cnt;
        foreach (sent_q[j]) check("loop_queue_empty", 32'd1, 32'd0);
        for (int w = 0; w < 4; w++) begin
            logic [8:0] words [4];
            words = '{9'h000, 9'h0FF, 9'h05A, 9'h0C3};
            @(negedge clk);
            tx_valid = 1'b1;
            tx_data  = words[w];
            @(negedge clk);
            tx_valid = 1'b0;
            wait_idle();
            repeat (20) @(negedge clk);
        end
        check("loop_count", 32'(rx_cnt - rx_before), 32'd4);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            tx_valid = ($urandom_range(0, 2) == 0);
            tx_data  = 9'($urandom);
            rst      = ($urandom_range(0, 599) == 0);
        end
        rst      = 1'b0;
        tx_valid = 1'b0;
        wait_idle();
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
